// File: rtl/pipo_shift_register.sv
// Parallel-in/parallel-out register chain of DEPTH stages with synchronous active-low reset.
// Optional stall control: define PIPO_LOAD_EN to add the Load_En port.
module pipo_shift_register #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
`ifdef PIPO_LOAD_EN
  input  logic                  Load_En,
`endif
  input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
  output logic [DATA_WIDTH-1:0] Parallel_Data_Out
);

  logic                  advance;
  logic [DATA_WIDTH-1:0] stage_reg [DEPTH];

`ifdef PIPO_LOAD_EN
  assign advance = Load_En;
`else
  assign advance = 1'b1;
`endif

  // The whole chain moves or holds together, so a stall never splits a word.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_reg[i] <= '0;
      end
    end else if (advance) begin
      stage_reg[0] <= Parallel_Data_In;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign Parallel_Data_Out = stage_reg[DEPTH-1];

endmodule

// File: tb/tb_pipo_shift_register.sv
// Directed bench for pipo_shift_register: three instances (8b/1 stage, 8b/3 stages, 16b/1 stage).
// Enable scenario runs only when PIPO_LOAD_EN is defined.
module tb_pipo_shift_register;

  logic        clk;
  logic        rst_n;
`ifdef PIPO_LOAD_EN
  logic        load_en;
`endif
  logic [7:0]  din1;
  logic [7:0]  dout1;
  logic [7:0]  din3;
  logic [7:0]  dout3;
  logic [15:0] din16;
  logic [15:0] dout16;

  int n_checks;
  int n_fail;

  pipo_shift_register #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
    .Clk_In            (clk),
    .Reset_In          (rst_n),
`ifdef PIPO_LOAD_EN
    .Load_En           (load_en),
`endif
    .Parallel_Data_In  (din1),
    .Parallel_Data_Out (dout1)
  );

  pipo_shift_register #(.DATA_WIDTH(8), .DEPTH(3)) dut3 (
    .Clk_In            (clk),
    .Reset_In          (rst_n),
`ifdef PIPO_LOAD_EN
    .Load_En           (load_en),
`endif
    .Parallel_Data_In  (din3),
    .Parallel_Data_Out (dout3)
  );

  pipo_shift_register #(.DATA_WIDTH(16), .DEPTH(1)) dut16 (
    .Clk_In            (clk),
    .Reset_In          (rst_n),
`ifdef PIPO_LOAD_EN
    .Load_En           (load_en),
`endif
    .Parallel_Data_In  (din16),
    .Parallel_Data_Out (dout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    din1  = 8'hFF;
    din3  = 8'hFF;
    din16 = 16'hFFFF;
    rst_n = 1'b0;
    step();
    n_checks++;
    if (dout1 !== 8'h00) begin
      n_fail++; $display("FAIL reset_d1: got %h expected 00", dout1);
    end
    n_checks++;
    if (dout3 !== 8'h00) begin
      n_fail++; $display("FAIL reset_d3: got %h expected 00", dout3);
    end
    n_checks++;
    if (dout16 !== 16'h0000) begin
      n_fail++; $display("FAIL reset_w16: got %h expected 0000", dout16);
    end
    $display("reset: in=FF out1=%h out3=%h out16=%h", dout1, dout3, dout16);
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    logic [7:0] vec [5];
    vec[0] = 8'h24; vec[1] = 8'h81; vec[2] = 8'h09; vec[3] = 8'h63; vec[4] = 8'h0D;
    for (int i = 0; i < 5; i++) begin
      din1 = vec[i];
      step();
      n_checks++;
      if (dout1 !== vec[i]) begin
        n_fail++; $display("FAIL capture[%0d]: got %h expected %h", i, dout1, vec[i]);
      end
      $display("capture: in=%h out=%h", vec[i], dout1);
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp_out [4];
    exp_out[0] = 8'h00; exp_out[1] = 8'h00; exp_out[2] = 8'hA5; exp_out[3] = 8'h00;
    din3 = 8'h00;
    reset_all();
    for (int i = 0; i < 4; i++) begin
      din3 = (i == 0) ? 8'hA5 : 8'h00;
      step();
      n_checks++;
      if (dout3 !== exp_out[i]) begin
        n_fail++; $display("FAIL latency[%0d]: got %h expected %h", i, dout3, exp_out[i]);
      end
      $display("latency: edge %0d out=%h", i + 1, dout3);
    end
  endtask

  task automatic test_midstream_reset();
    reset_all();
    din3 = 8'h11; step();
    din3 = 8'h22; step();
    n_checks++;
    if (dout3 !== 8'h00) begin
      n_fail++; $display("FAIL mid_prefill: got %h expected 00", dout3);
    end
    din3  = 8'h33;
    rst_n = 1'b0;
    step();
    n_checks++;
    if (dout3 !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset: got %h expected 00", dout3);
    end
    rst_n = 1'b1;
    din3  = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dout3 !== 8'h00) begin
        n_fail++; $display("FAIL mid_flush[%0d]: got %h expected 00", i, dout3);
      end
      $display("mid_reset: edge %0d out=%h", i, dout3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [6];
    logic [7:0] exp_out [6];
    words[0] = 8'h5A; words[1] = 8'hC1; words[2] = 8'h3E;
    words[3] = 8'h77; words[4] = 8'h00; words[5] = 8'h00;
    exp_out[0] = 8'h00; exp_out[1] = 8'h00; exp_out[2] = 8'h5A;
    exp_out[3] = 8'hC1; exp_out[4] = 8'h3E; exp_out[5] = 8'h77;
    reset_all();
    for (int i = 0; i < 6; i++) begin
      din3 = words[i];
      step();
      n_checks++;
      if (dout3 !== exp_out[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h expected %h", i, dout3, exp_out[i]);
      end
      $display("b2b: in=%h out=%h", words[i], dout3);
    end
  endtask

  // Reset is sampled only at edges: a pulse that ends before the edge must not clear.
  task automatic test_reset_between_edges();
    din1 = 8'h6B;
    step();
    din1 = 8'h6B;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n_checks++;
    if (dout1 !== 8'h6B) begin
      n_fail++; $display("FAIL glitch_reset_now: got %h expected 6B", dout1);
    end
    step();
    n_checks++;
    if (dout1 !== 8'h6B) begin
      n_fail++; $display("FAIL glitch_reset_edge: got %h expected 6B", dout1);
    end
    $display("reset_between_edges: out=%h", dout1);
  endtask

  task automatic test_width();
    logic [15:0] pat;
    reset_all();
    for (int b = 0; b < 16; b++) begin
      pat   = 16'h0001 << b;
      din16 = pat;
      step();
      n_checks++;
      if (dout16 !== pat) begin
        n_fail++; $display("FAIL width_bit%0d: got %h expected %h", b, dout16, pat);
      end
      $display("width: in=%h out=%h", pat, dout16);
    end
  endtask

`ifdef PIPO_LOAD_EN
  task automatic test_enable();
    reset_all();
    load_en = 1'b1;
    din1    = 8'h3C;
    step();
    n_checks++;
    if (dout1 !== 8'h3C) begin
      n_fail++; $display("FAIL en_load: got %h expected 3C", dout1);
    end
    load_en = 1'b0;
    din1    = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dout1 !== 8'h3C) begin
        n_fail++; $display("FAIL en_hold[%0d]: got %h expected 3C", i, dout1);
      end
      $display("enable: hold edge %0d out=%h", i, dout1);
    end
    load_en = 1'b1;
    step();
    n_checks++;
    if (dout1 !== 8'hC3) begin
      n_fail++; $display("FAIL en_resume: got %h expected C3", dout1);
    end
    load_en = 1'b0;
    rst_n   = 1'b0;
    step();
    n_checks++;
    if (dout1 !== 8'h00) begin
      n_fail++; $display("FAIL en_reset_priority: got %h expected 00", dout1);
    end
    rst_n   = 1'b1;
    load_en = 1'b1;
    $display("enable: resume/reset out=%h", dout1);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
`ifdef PIPO_LOAD_EN
    load_en  = 1'b1;
`endif
    din1  = 8'h00;
    din3  = 8'h00;
    din16 = 16'h0000;
    @(negedge clk);
    test_reset();
    test_capture();
    test_latency();
    test_midstream_reset();
    test_back_to_back();
    test_reset_between_edges();
    test_width();
`ifdef PIPO_LOAD_EN
    test_enable();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
